hub75_row_capture: RTL and testbench
====================================

# hub75_row_capture

Panel-side capture stage for the 32x32 LED panel bus: it consumes exactly what the panel driver emits (r0/g0/b0/r1/g1/b1, a[3:0], blank, latch, shift clock). It oversamples the bus on its own clock, rebuilds every latched row pair into a 16x32x6-bit row store, and flags malformed rows. It sits directly downstream of the driver, in the FPGA for loopback self-check and in benches as the scoreboard source.

## Interface
- COLS, 32, shifts expected per row; a latch with any other count is an error.
- ADDR_W, 4, row-address width; the store depth is 2**ADDR_W row pairs.
- ONTIME_W, 16, width of the blank-low on-time counter.
- sclk  in  1  oversampling clock; at least 4x the panel shift-clock rate.
- rst_n  in  1  reset: synchronous, active-low.
- pnl_clk  in  1  panel shift clock, asynchronous.
- pnl_lat  in  1  panel latch, asynchronous.
- pnl_blank  in  1  panel blank, active high, asynchronous.
- pnl_a  in  ADDR_W  panel row address.
- pnl_rgb0  in  3  {r0,g0,b0}, upper half.
- pnl_rgb1  in  3  {r1,g1,b1}, lower half.
- rd_addr  in  ADDR_W+5  {row, col} readback address.
- rd_data  out  6  {rgb0, rgb1} at rd_addr; registered.
- row_valid  out  1  one-cycle pulse per committed row.
- row_addr  out  ADDR_W  row committed with the last row_valid.
- row_cols  out  6  shift count of the last row; saturates at 63.
- row_err  out  1  sticky; set when row_cols != COLS at latch; cleared only by reset.
- ontime  out  ONTIME_W  sclk cycles with blank low during the previous latch period.

## Operation
- All pnl_* inputs pass through a 2-flop synchronizer of equal depth, which keeps data aligned with the clock and latch.
- Edge detection compares each synchronized value with a third flop. Edges are masked for 3 cycles after reset release while the synchronizers fill.
- Rising pnl_clk: shift {rgb0,rgb1} into a COLS-entry register. New data enters at index COLS-1 and everything moves toward 0, so the first bit shifted lands in column 0. col_cnt increments and saturates at 63.
- Rising pnl_lat: the shift register is written to store row pnl_a (the synchronized value in that cycle). row_valid pulses, row_addr and row_cols update, row_err is set if the count is wrong, and col_cnt clears. The shift register is not cleared.
- Clock rise and latch rise in the same sclk cycle: the shift happens first, and the committed row includes the new bit.
- Latch with col_cnt = 0: the row is still committed (stale shift contents), row_cols = 0, and row_err is set.
- Row store is a register file or distributed RAM. A write to the row being read in the same cycle returns the old data.
- Reset mid-row: the partial row is discarded. Store contents are retained but are unspecified before their first write.

## Timing
- Reset values: rd_data 0, row_valid 0, row_addr 0, row_cols 0, row_err 0, ontime 0. col_cnt, the shift register and all edge flops are also 0.
- Panel-input edge to internal action: 3 sclk cycles.
- pnl_lat rise to row_valid: 3 cycles. row_addr, row_cols and row_err are valid in the same cycle as row_valid.
- rd_addr to rd_data: 1 cycle.
- pnl_clk high and low phases must each last at least 2 sclk periods. Data must be stable from 1 sclk before the clock rise until 1 sclk after it. Violations are not detected.

## Configuration
- HUB75_CAP_ONTIME_EN defined: a counter increments on every sclk with synchronized blank = 0 and saturates at all-ones. On latch rise, ontime takes the counter value and the counter restarts at 0; the latch cycle itself is not counted.
- HUB75_CAP_ONTIME_EN undefined: the counter is not built, and ontime is constant 0.

## Structure
- Package hub75_cap_pkg: COLS and ADDR_W defaults, the synchronizer depth (2), the post-reset edge-mask length (3), and the 6-bit pixel bit order {r0,g0,b0,r1,g1,b1}.
- Sub-module hub75_sync_edge: a synchronizer plus rise detector, instantiated once per control input and vectored for the data bits.

## Test plan
- Shift 32 columns (col0 = 3'b100/3'b001, all others 0), then latch with a = 5 -> row_valid, row_addr 5, row_cols 32, row_err 0; rd_addr {5,0} gives 6'b100001, {5,1} gives 0.
- Shift 31 columns, then latch with a = 2 -> row_cols 31, row_err 1 and stays 1 through later good rows until reset.
- Clock rise and latch rise in the same sclk cycle after 31 shifts -> row_cols 32, and the last bit appears in column 31.
- Blank low for 100 sclk between two latches, macro on -> ontime 100 at the second latch; macro off -> ontime 0.
- Reset asserted after 10 shifts with pnl_clk held high through release -> no shift for 3 cycles; a following 32-shift row commits with row_cols 32.
- Write row 7 while reading {7,3} in the same cycle -> rd_data shows old data, and the new data on the next read.

Source files
------------

// File: rtl/hub75_row_capture_pkg.sv
// Shared constants and pixel layout for the HUB75 row-capture slice.
package hub75_cap_pkg;

  localparam int COLS_DEF      = 32;
  localparam int ADDR_W_DEF    = 4;
  localparam int SYNC_DEPTH    = 2;
  localparam int EDGE_MASK_CYC = 3;
  localparam int CNT_W         = 6;

  // Bit order {r0,g0,b0,r1,g1,b1}: upper-half colour in the high bits.
  typedef struct packed {
    logic r0;
    logic g0;
    logic b0;
    logic r1;
    logic g1;
    logic b1;
  } pix_t;

  function automatic pix_t pack_pix(input logic [2:0] rgb0, input logic [2:0] rgb1);
    pix_t p;
    p = {rgb0, rgb1};
    return p;
  endfunction

endpackage

// File: rtl/hub75_row_capture_if.sv
// Panel bus as emitted by the HUB75 driver; master = driver, slave = capture.
interface hub75_row_capture_if
  import hub75_cap_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              pnl_clk;
  logic              pnl_lat;
  logic              pnl_blank;
  logic [ADDR_W-1:0] pnl_a;
  logic [2:0]        pnl_rgb0;
  logic [2:0]        pnl_rgb1;

  modport master (
    output pnl_clk, pnl_lat, pnl_blank, pnl_a, pnl_rgb0, pnl_rgb1
  );

  modport slave (
    input pnl_clk, pnl_lat, pnl_blank, pnl_a, pnl_rgb0, pnl_rgb1
  );

endinterface

// File: rtl/hub75_row_capture_sync_edge.sv
// Equal-depth synchronizer plus rise detector; rises are suppressed while i_mask is high.
module hub75_sync_edge
  import hub75_cap_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         sclk,
  input  logic         rst_n,
  input  logic         i_mask,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_sync [SYNC_DEPTH];
  logic [W-1:0] r_prev;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_DEPTH-1];
    end
  end

  assign o_sync = r_sync[SYNC_DEPTH-1];
  assign o_rise = o_sync & ~r_prev & {W{~i_mask}};

endmodule

// File: rtl/hub75_row_capture.sv
// Oversampling HUB75 capture: rebuilds latched rows into a row store and flags bad shift counts.
// Define HUB75_CAP_ONTIME_EN to build the blank-low on-time counter; otherwise o_ontime is 0.
module hub75_row_capture
  import hub75_cap_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ONTIME_W = 16
) (
  input  logic                sclk,
  input  logic                rst_n,
  hub75_row_capture_if.slave  pnl,
  input  logic [ADDR_W+4:0]   i_rd_addr,
  output logic [5:0]          o_rd_data,
  output logic                o_row_valid,
  output logic [ADDR_W-1:0]   o_row_addr,
  output logic [CNT_W-1:0]    o_row_cols,
  output logic                o_row_err,
  output logic [ONTIME_W-1:0] o_ontime
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int DAT_W  = ADDR_W + 7;
  localparam int MASK_W = $clog2(EDGE_MASK_CYC + 1);

  logic [MASK_W-1:0] r_mask_cnt;
  logic              w_mask;

  logic              w_clk_rise;
  logic              w_lat_rise;
  logic              w_clk_sync_unused;
  logic              w_lat_sync_unused;
  logic [DAT_W-1:0]  w_dat_s;
  logic [DAT_W-1:0]  w_dat_rise_unused;
  logic              w_blank_s;
  logic [ADDR_W-1:0] w_a_s;
  pix_t              w_pix_s;

  pix_t              r_shift [COLS];
  pix_t              w_shift_nxt [COLS];
  logic [CNT_W-1:0]  r_col_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  pix_t              r_store [DEPTH][COLS];
  pix_t              r_rd_data;
  logic              r_row_valid;
  logic [ADDR_W-1:0] r_row_addr;
  logic [CNT_W-1:0]  r_row_cols;
  logic              r_row_err;

  logic [ADDR_W-1:0] w_rd_row;
  logic [4:0]        w_rd_col;

  // Synchronizers start at 0, so a line already high at reset release would look like a rise.
  assign w_mask = (r_mask_cnt != '0);

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_mask_cnt <= MASK_W'(EDGE_MASK_CYC);
    end else if (w_mask) begin
      r_mask_cnt <= r_mask_cnt - 1'b1;
    end
  end

  hub75_sync_edge #(.W(1)) u_sync_clk (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .i_mask (w_mask),
    .i_d    (pnl.pnl_clk),
    .o_sync (w_clk_sync_unused),
    .o_rise (w_clk_rise)
  );

  hub75_sync_edge #(.W(1)) u_sync_lat (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .i_mask (w_mask),
    .i_d    (pnl.pnl_lat),
    .o_sync (w_lat_sync_unused),
    .o_rise (w_lat_rise)
  );

  hub75_sync_edge #(.W(DAT_W)) u_sync_dat (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .i_mask (w_mask),
    .i_d    ({pnl.pnl_blank, pnl.pnl_a, pnl.pnl_rgb0, pnl.pnl_rgb1}),
    .o_sync (w_dat_s),
    .o_rise (w_dat_rise_unused)
  );

  assign w_blank_s = w_dat_s[DAT_W-1];
  assign w_a_s     = w_dat_s[ADDR_W+5:6];
  assign w_pix_s   = pack_pix(w_dat_s[5:3], w_dat_s[2:0]);

  // Shift is resolved before the latch so a same-cycle clock rise lands in the committed row.
  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      w_shift_nxt[i] = r_shift[i];
    end
    w_cnt_nxt = r_col_cnt;
    if (w_clk_rise) begin
      for (int i = 0; i < COLS - 1; i++) begin
        w_shift_nxt[i] = r_shift[i+1];
      end
      w_shift_nxt[COLS-1] = w_pix_s;
      if (r_col_cnt != '1) begin
        w_cnt_nxt = r_col_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++) begin
        r_shift[i] <= '0;
      end
      r_col_cnt   <= '0;
      r_row_valid <= 1'b0;
      r_row_addr  <= '0;
      r_row_cols  <= '0;
      r_row_err   <= 1'b0;
    end else begin
      for (int i = 0; i < COLS; i++) begin
        r_shift[i] <= w_shift_nxt[i];
      end
      r_row_valid <= w_lat_rise;
      if (w_lat_rise) begin
        r_col_cnt  <= '0;
        r_row_addr <= w_a_s;
        r_row_cols <= w_cnt_nxt;
        if (w_cnt_nxt != CNT_W'(COLS)) begin
          r_row_err <= 1'b1;
        end
      end else begin
        r_col_cnt <= w_cnt_nxt;
      end
    end
  end

  // Store has no reset; a same-cycle write and read of one entry returns the pre-write data.
  always_ff @(posedge sclk) begin
    if (rst_n && w_lat_rise) begin
      for (int c = 0; c < COLS; c++) begin
        r_store[w_a_s][c] <= w_shift_nxt[c];
      end
    end
  end

  assign w_rd_row = i_rd_addr[ADDR_W+4:5];
  assign w_rd_col = i_rd_addr[4:0];

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_store[w_rd_row][w_rd_col];
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_row_valid = r_row_valid;
  assign o_row_addr  = r_row_addr;
  assign o_row_cols  = r_row_cols;
  assign o_row_err   = r_row_err;

`ifdef HUB75_CAP_ONTIME_EN
  logic [ONTIME_W-1:0] r_on_cnt;
  logic [ONTIME_W-1:0] r_ontime;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_on_cnt <= '0;
      r_ontime <= '0;
    end else if (w_lat_rise) begin
      r_ontime <= r_on_cnt;
      r_on_cnt <= '0;
    end else if (!w_blank_s && (r_on_cnt != '1)) begin
      r_on_cnt <= r_on_cnt + 1'b1;
    end
  end

  assign o_ontime = r_ontime;
`else
  logic w_blank_unused;
  assign w_blank_unused = w_blank_s;
  assign o_ontime       = '0;
`endif

endmodule

// File: tb/tb_hub75_row_capture.sv
// Directed bench for hub75_row_capture: drives the panel bus at 5 sclk per column.
`timescale 1ns/1ps
module tb_hub75_row_capture;
  import hub75_cap_pkg::*;

`ifdef HUB75_CAP_ONTIME_EN
  localparam logic [15:0] ONTIME_EXP = 16'd100;
`else
  localparam logic [15:0] ONTIME_EXP = 16'd0;
`endif

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  rd_addr = '0;
  logic [5:0]  rd_data;
  logic        row_valid;
  logic [3:0]  row_addr;
  logic [5:0]  row_cols;
  logic        row_err;
  logic [15:0] ontime;

  int n_vec = 0;
  int n_err = 0;

  hub75_row_capture_if #(.ADDR_W(4)) pnl ();

  hub75_row_capture #(.COLS(32), .ADDR_W(4), .ONTIME_W(16)) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .pnl         (pnl),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_row_valid (row_valid),
    .o_row_addr  (row_addr),
    .o_row_cols  (row_cols),
    .o_row_err   (row_err),
    .o_ontime    (ontime)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_col(input logic [2:0] c0, input logic [2:0] c1);
    pnl.pnl_rgb0 = c0;
    pnl.pnl_rgb1 = c1;
    tick();
    pnl.pnl_clk = 1'b1;
    tick();
    tick();
    pnl.pnl_clk = 1'b0;
    tick();
    tick();
  endtask

  task automatic latch_commit(input string tag, input logic [3:0] a, input logic [5:0] cols,
                              input logic err, input bit with_clk);
    pnl.pnl_a = a;
    tick();
    pnl.pnl_lat = 1'b1;
    if (with_clk) pnl.pnl_clk = 1'b1;
    tick();
    chk({tag, ".early1"}, 32'(row_valid), 32'd0);
    tick();
    chk({tag, ".early2"}, 32'(row_valid), 32'd0);
    tick();
    chk({tag, ".valid"}, 32'(row_valid), 32'd1);
    chk({tag, ".addr"}, 32'(row_addr), 32'(a));
    chk({tag, ".cols"}, 32'(row_cols), 32'(cols));
    chk({tag, ".err"}, 32'(row_err), 32'(err));
  endtask

  task automatic finish_latch(input string tag);
    tick();
    chk({tag, ".pulse"}, 32'(row_valid), 32'd0);
    pnl.pnl_lat = 1'b0;
    pnl.pnl_clk = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] row, input logic [4:0] col,
                        input logic [5:0] exp);
    rd_addr = {row, col};
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] cv;
    pnl.pnl_clk   = 1'b0;
    pnl.pnl_lat   = 1'b0;
    pnl.pnl_blank = 1'b1;
    pnl.pnl_a     = '0;
    pnl.pnl_rgb0  = '0;
    pnl.pnl_rgb1  = '0;

    // Reset values, sampled while reset is held
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst.rd_data", 32'(rd_data), 32'd0);
    chk("rst.row_valid", 32'(row_valid), 32'd0);
    chk("rst.row_addr", 32'(row_addr), 32'd0);
    chk("rst.row_cols", 32'(row_cols), 32'd0);
    chk("rst.row_err", 32'(row_err), 32'd0);
    chk("rst.ontime", 32'(ontime), 32'd0);
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();

    // Single lit pixel in column 0
    for (int c = 0; c < 32; c++) begin
      shift_col((c == 0) ? 3'b100 : 3'b000, (c == 0) ? 3'b001 : 3'b000);
    end
    latch_commit("row5", 4'd5, 6'd32, 1'b0, 1'b0);
    finish_latch("row5");
    rd_chk("row5.c0", 4'd5, 5'd0, 6'b100001);
    rd_chk("row5.c1", 4'd5, 5'd1, 6'b000000);

    // Column-dependent pattern: rgb0 = col[2:0], rgb1 = ~col[2:0]
    for (int c = 0; c < 32; c++) begin
      cv = 5'(c);
      shift_col(cv[2:0], ~cv[2:0]);
    end
    latch_commit("row9", 4'd9, 6'd32, 1'b0, 1'b0);
    finish_latch("row9");
    rd_chk("row9.c0", 4'd9, 5'd0, 6'b000111);
    rd_chk("row9.c17", 4'd9, 5'd17, 6'b001110);
    rd_chk("row9.c31", 4'd9, 5'd31, 6'b111000);

    // Latch with no shifts commits the stale shift register
    latch_commit("zero", 4'd3, 6'd0, 1'b1, 1'b0);
    finish_latch("zero");
    rd_chk("zero.c0", 4'd3, 5'd0, 6'b000111);
    rd_chk("zero.c5", 4'd3, 5'd5, 6'b101010);

    // Reset clears the sticky error; short row sets it and it stays set
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst2.row_err", 32'(row_err), 32'd0);
    chk("rst2.row_cols", 32'(row_cols), 32'd0);
    tick(); tick(); tick();
    for (int c = 0; c < 31; c++) shift_col(3'b000, 3'b000);
    latch_commit("short", 4'd2, 6'd31, 1'b1, 1'b0);
    finish_latch("short");
    for (int c = 0; c < 32; c++) shift_col(3'b000, 3'b000);
    latch_commit("sticky", 4'd4, 6'd32, 1'b1, 1'b0);
    finish_latch("sticky");

    // Clock rise coinciding with latch rise: last bit lands in column 31
    for (int c = 0; c < 31; c++) shift_col(3'b000, 3'b000);
    pnl.pnl_rgb0 = 3'b111;
    pnl.pnl_rgb1 = 3'b111;
    latch_commit("simul", 4'd6, 6'd32, 1'b1, 1'b1);
    finish_latch("simul");
    pnl.pnl_rgb0 = 3'b000;
    pnl.pnl_rgb1 = 3'b000;
    rd_chk("simul.c31", 4'd6, 5'd31, 6'b111111);
    rd_chk("simul.c30", 4'd6, 5'd30, 6'b000000);

    // Blank low for 100 sclk between two latches
    latch_commit("on_a", 4'd1, 6'd0, 1'b1, 1'b0);
    chk("on_a.ontime", 32'(ontime), 32'd0);
    finish_latch("on_a");
    pnl.pnl_blank = 1'b0;
    repeat (100) tick();
    pnl.pnl_blank = 1'b1;
    tick(); tick(); tick();
    latch_commit("on_b", 4'd1, 6'd0, 1'b1, 1'b0);
    chk("on_b.ontime", 32'(ontime), 32'(ONTIME_EXP));
    finish_latch("on_b");

    // Reset mid-row with the shift clock held high through release
    for (int c = 0; c < 10; c++) shift_col(3'b111, 3'b111);
    pnl.pnl_clk = 1'b1;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    pnl.pnl_clk = 1'b0;
    tick(); tick();
    chk("midrst.row_cols", 32'(row_cols), 32'd0);
    chk("midrst.row_err", 32'(row_err), 32'd0);
    for (int c = 0; c < 32; c++) begin
      shift_col((c == 0) ? 3'b010 : 3'b000, (c == 0) ? 3'b010 : 3'b000);
    end
    latch_commit("after_rst", 4'd8, 6'd32, 1'b0, 1'b0);
    finish_latch("after_rst");
    rd_chk("after_rst.c0", 4'd8, 5'd0, 6'b010010);

    // Write row 7 while reading {7,3}
    for (int c = 0; c < 32; c++) begin
      shift_col((c == 3) ? 3'b101 : 3'b000, (c == 3) ? 3'b010 : 3'b000);
    end
    latch_commit("row7a", 4'd7, 6'd32, 1'b0, 1'b0);
    finish_latch("row7a");
    rd_chk("row7a.c3", 4'd7, 5'd3, 6'b101010);
    for (int c = 0; c < 32; c++) begin
      shift_col((c == 3) ? 3'b011 : 3'b000, (c == 3) ? 3'b110 : 3'b000);
    end
    latch_commit("row7b", 4'd7, 6'd32, 1'b0, 1'b0);
    chk("row7b.rd_old", 32'(rd_data), 32'(6'b101010));
    finish_latch("row7b");
    chk("row7b.rd_new", 32'(rd_data), 32'(6'b011110));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
